// File: rtl/hyperbus_ca_gen.sv
// HyperBus command-address generator: turns a word-addressed burst request into
// one or more row-bounded segments, each emitted as three 16-bit CA beats.
module hyperbus_ca_gen #(
    parameter int ADDR_W = 22,
    parameter int COL_W  = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_reg,
    input  logic              req_linear,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              ca_valid,
    input  logic              ca_ready,
    output logic [15:0]       ca_data,
    output logic              ca_first,
    output logic              ca_last,
    output logic [ADDR_W-1:0] seg_addr,
    output logic [LEN_W:0]    seg_len,
    output logic              seg_last,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CA0, CA1, CA2} state_t;

    localparam int CMP_W = ((LEN_W > COL_W) ? LEN_W : COL_W) + 1;
    localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};
    localparam logic [COL_W:0] ROW_WORDS = {1'b1, {COL_W{1'b0}}};

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic              reg_q, reg_d;
    logic              linear_q, linear_d;
    logic [ADDR_W-1:0] seg_addr_q, seg_addr_d;
    logic [LEN_W:0]    rem_q, rem_d;
    logic [LEN_W:0]    seg_len_q, seg_len_d;
    logic              seg_last_q, seg_last_d;

    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W:0]    next_rem;
    logic [47:0]       ca_word;
    logic [15:0]       beat [3];

    // Words left before the next row boundary caps the segment only when splitting.
    function automatic logic [LEN_W:0] calc_seg_len(
        input logic [LEN_W:0]   rem,
        input logic [COL_W-1:0] col,
        input logic             split
    );
        logic [COL_W:0]   room;
        logic [CMP_W-1:0] room_w;
        logic [CMP_W-1:0] rem_w;
        room   = ROW_WORDS - {1'b0, col};
        room_w = CMP_W'(room);
        rem_w  = CMP_W'(rem);
        if (split && (room_w < rem_w)) begin
            return (LEN_W+1)'(room_w);
        end
        return rem;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            reg_q      <= 1'b0;
            linear_q   <= 1'b0;
            seg_addr_q <= '0;
            rem_q      <= '0;
            seg_len_q  <= '0;
            seg_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            reg_q      <= reg_d;
            linear_q   <= linear_d;
            seg_addr_q <= seg_addr_d;
            rem_q      <= rem_d;
            seg_len_q  <= seg_len_d;
            seg_last_q <= seg_last_d;
        end
    end

    assign next_addr = seg_addr_q + ADDR_W'(seg_len_q);
    assign next_rem  = rem_q - seg_len_q;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        reg_d      = reg_q;
        linear_d   = linear_q;
        seg_addr_d = seg_addr_q;
        rem_d      = rem_q;
        seg_len_d  = seg_len_q;
        seg_last_d = seg_last_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    reg_d      = req_reg;
                    linear_d   = req_linear;
                    seg_addr_d = req_addr;
                    rem_d      = (req_len == '0) ? FULL_LEN : {1'b0, req_len};
                    seg_len_d  = calc_seg_len(rem_d, req_addr[COL_W-1:0],
                                              req_linear && !req_reg);
                    seg_last_d = (seg_len_d == rem_d);
                    state_d    = CA0;
                end
            end
            CA0: begin
                if (ca_ready) state_d = CA1;
            end
            CA1: begin
                if (ca_ready) state_d = CA2;
            end
            CA2: begin
                if (ca_ready) begin
                    if (seg_last_q) begin
                        state_d = IDLE;
                    end else begin
                        seg_addr_d = next_addr;
                        rem_d      = next_rem;
                        seg_len_d  = calc_seg_len(next_rem, next_addr[COL_W-1:0],
                                                  linear_q && !reg_q);
                        seg_last_d = (seg_len_d == next_rem);
                        state_d    = CA0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ca_word = {!write_q, reg_q, linear_q, 29'(seg_addr_q[ADDR_W-1:3]),
                      13'b0, seg_addr_q[2:0]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_beat
            assign beat[gi] = ca_word[47-16*gi -: 16];
        end
    endgenerate

    // Beats are decoded straight from the state register so reset kills them at once.
    always_comb begin
        ca_data = '0;
        case (state_q)
            CA0:     ca_data = beat[0];
            CA1:     ca_data = beat[1];
            CA2:     ca_data = beat[2];
            default: ca_data = '0;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign ca_valid  = (state_q != IDLE);
    assign ca_first  = (state_q == CA0);
    assign ca_last   = (state_q == CA2);
    assign seg_addr  = seg_addr_q;
    assign seg_len   = seg_len_q;
    assign seg_last  = seg_last_q;

endmodule
